// File: rtl/pool_window_gen.sv
// Gathers a raster pixel stream into non-overlapping 2x2 windows for the max-pooling stage.
// Optional status outputs (win_count, frame_done) are enabled by defining POOL_WIN_STATUS_EN.
module pool_window_gen #(
   parameter int DATA_WIDTH  = 20,
   parameter int FMAP_WIDTH  = 8,
   parameter int FMAP_HEIGHT = 8,
   parameter int POOL_SIZE   = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] win_data [POOL_SIZE],
   output logic                         out_last
`ifdef POOL_WIN_STATUS_EN
   ,
   output logic [15:0]                  win_count,
   output logic [0:0]                   frame_done
`endif
);
   localparam int CW = (FMAP_WIDTH  > 2) ? $clog2(FMAP_WIDTH)  : 1;
   localparam int RW = (FMAP_HEIGHT > 2) ? $clog2(FMAP_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(FMAP_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(FMAP_HEIGHT - 1);

   typedef enum logic {FILL_TOP, FILL_BOT} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                col_q, col_d;
   logic [RW-1:0]                row_q, row_d;
   logic                         out_valid_q, out_valid_d;
   logic                         out_last_q, out_last_d;
   logic signed [DATA_WIDTH-1:0] win_q [POOL_SIZE];
   logic signed [DATA_WIDTH-1:0] win_d [POOL_SIZE];
   logic signed [DATA_WIDTH-1:0] linebuf_q [FMAP_WIDTH];
   logic signed [DATA_WIDTH-1:0] bl_q;
   logic                         accept;
   logic                         col_wrap;
   logic                         load_win;

   // Stall only while a finished window is still waiting for the consumer.
   assign in_ready = rst_n && !(out_valid_q && !out_ready);
   assign accept   = in_valid && in_ready;
   assign col_wrap = (col_q == COL_MAX);
   assign load_win = accept && (state_q == FILL_BOT) && col_q[0];

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      for (int i = 0; i < POOL_SIZE; i++) win_d[i] = win_q[i];

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         col_d = col_wrap ? '0 : col_q + CW'(1);
         if (col_wrap) begin
            row_d   = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            state_d = (state_q == FILL_TOP) ? FILL_BOT : FILL_TOP;
         end
      end

      // Odd column of an odd row closes a window; col^1 is its left neighbour.
      if (load_win) begin
         win_d[0]    = linebuf_q[col_q ^ CW'(1)];
         win_d[1]    = linebuf_q[col_q];
         win_d[2]    = bl_q;
         win_d[3]    = in_data;
         out_valid_d = 1'b1;
         out_last_d  = col_wrap && (row_q == ROW_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FILL_TOP;
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < POOL_SIZE; i++) win_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         for (int i = 0; i < POOL_SIZE; i++) win_q[i] <= win_d[i];
      end
   end

   // Line buffer and bottom-left holding register carry data only; no reset needed.
   always_ff @(posedge clk) begin
      if (accept && (state_q == FILL_TOP)) linebuf_q[col_q] <= in_data;
      if (accept && (state_q == FILL_BOT) && !col_q[0]) bl_q <= in_data;
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign win_data  = win_q;

`ifdef POOL_WIN_STATUS_EN
   logic [15:0] win_count_q;
   logic        frame_done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_count_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         if (out_valid_q && out_ready) win_count_q <= win_count_q + 16'd1;
         frame_done_q <= out_valid_q && out_ready && out_last_q;
      end
   end

   assign win_count  = win_count_q;
   assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen: per-cycle reference model plus directed literal windows.
`timescale 1ns/1ps
module tb_pool_window_gen;
   localparam int DW = 20;
   localparam int W  = 4;
   localparam int H  = 4;

   typedef struct packed {
      logic                last;
      logic [3:0][DW-1:0]  w;
   } win_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 out_ready = 1'b0;
   logic                 in_ready, out_valid, out_last;
   logic signed [DW-1:0] in_data = '0;
   logic signed [DW-1:0] win_data [4];

   logic                 v2 = 1'b0;
   logic                 rdy2, ov2, ol2;
   logic signed [DW-1:0] d2 = '0;
   logic signed [DW-1:0] w2 [4];
`ifdef POOL_WIN_STATUS_EN
   logic [15:0]          win_count, wc2;
   logic [0:0]           frame_done, fd2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pool_window_gen #(.DATA_WIDTH(DW), .FMAP_WIDTH(W), .FMAP_HEIGHT(H), .POOL_SIZE(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .win_data(win_data), .out_last(out_last)
`ifdef POOL_WIN_STATUS_EN
      , .win_count(win_count), .frame_done(frame_done)
`endif
   );

   pool_window_gen #(.DATA_WIDTH(DW), .FMAP_WIDTH(2), .FMAP_HEIGHT(2), .POOL_SIZE(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
      .out_valid(ov2), .out_ready(1'b1), .win_data(w2), .out_last(ol2)
`ifdef POOL_WIN_STATUS_EN
      , .win_count(wc2), .frame_done(fd2)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, $signed(got), $signed(exp));
      end
   endtask

   // Reference model: frame image indexed by raster position, queue of expected windows.
   win_t                 q[$];
   win_t                 log_q[$];
   win_t                 me, de;
   logic signed [DW-1:0] fm [H][W];
   int                   idx = 0;
   int                   r, c;
   bit                   active = 1'b0;
   bit                   exp_rdy;
   int                   exp_cnt = 0;
   bit                   exp_fd = 1'b0;
   int                   fd_pulses = 0;

   always @(negedge clk) if (active) begin
      exp_rdy = rst_n && !(q.size() != 0 && !out_ready);
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, exp_rdy);
      if (q.size() != 0 && out_valid) begin
         me = q[0];
         for (int i = 0; i < 4; i++)
            chk($sformatf("win_data[%0d]", i), win_data[i], $signed(me.w[i]));
         chk("out_last", out_last, me.last);
      end
`ifdef POOL_WIN_STATUS_EN
      chk("win_count", win_count, exp_cnt[15:0]);
      chk("frame_done", frame_done, exp_fd);
      if (frame_done) fd_pulses++;
`endif
      exp_fd = 1'b0;
      if (!rst_n) begin
         q.delete();
         idx     = 0;
         exp_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            for (int i = 0; i < 4; i++) de.w[i] = win_data[i];
            de.last = out_last;
            log_q.push_back(de);
         end
         if (out_ready && q.size() != 0) begin
            me = q.pop_front();
            exp_cnt++;
            exp_fd = me.last;
         end
         if (in_valid && exp_rdy) begin
            r = idx / W;
            c = idx % W;
            fm[r][c] = in_data;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
               me.w[0] = fm[r-1][c-1];
               me.w[1] = fm[r-1][c];
               me.w[2] = fm[r][c-1];
               me.w[3] = in_data;
               me.last = (idx == W*H - 1);
               q.push_back(me);
            end
            idx = (idx + 1) % (W*H);
         end
      end
   end

   bit or_rand = 1'b0;
   bit or_val  = 1'b1;
   int gap_mode = 0;
   int cyc = 0;

   always @(posedge clk) begin
      cyc++;
      #2;
      out_ready = or_rand ? ($urandom_range(0, 3) != 0) : or_val;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic send_pix(input logic signed [DW-1:0] v);
      bit acc;
      if ((gap_mode == 1 && cyc % 3 == 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v;
      do begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
      end while (!acc);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int base);
      for (int p = 0; p < W*H; p++) send_pix(DW'(base + p));
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain timeout", n < 100, 1);
   endtask

   task automatic chkw(input string nm, input int k, input int a, input int b,
                       input int cc, input int d, input bit l);
      win_t e;
      int   ex[4];
      ex = '{a, b, cc, d};
      if (k >= log_q.size()) begin
         checks++;
         errors++;
         $display("FAIL %s: got %0d windows required more than %0d", nm, log_q.size(), k);
         return;
      end
      e = log_q[k];
      for (int i = 0; i < 4; i++) chk($sformatf("%s[%0d]", nm, i), $signed(e.w[i]), ex[i]);
      chk({nm, " last"}, e.last, l);
   endtask

   task automatic chk_frame0(input string nm, input int off);
      chkw({nm, " w0"}, off + 0, 0, 1, 4, 5, 0);
      chkw({nm, " w1"}, off + 1, 2, 3, 6, 7, 0);
      chkw({nm, " w2"}, off + 2, 8, 9, 12, 13, 0);
      chkw({nm, " w3"}, off + 3, 10, 11, 14, 15, 1);
   endtask

   int vals2[4];
   int nwait;
   bit seen;

   initial begin
      repeat (40000) @(posedge clk);
      $display("FAIL watchdog: got no finish required finish within cycle budget");
      $fatal(1);
   end

   initial begin
      do_reset();
      active = 1'b1;
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_last", out_last, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("reset win_data[%0d]", i), win_data[i], 0);
      @(posedge clk); #1;

      // Plain 4x4 frame, continuous input, consumer always ready.
      log_q.delete();
      send_frame(0);
      drain();
      chk("t1 windows", log_q.size(), 4);
      chk_frame0("t1", 0);

      // Signed extremes through a 2x2 instance.
      do_reset();
      vals2 = '{-1, -524288, 524287, 0};
      for (int k = 0; k < 4; k++) begin
         v2 = 1'b1;
         d2 = DW'(vals2[k]);
         @(negedge clk); chk("t2 in_ready", rdy2, 1);
         @(posedge clk); #1;
      end
      v2 = 1'b0;
      @(negedge clk);
      chk("t2 out_valid", ov2, 1);
      for (int i = 0; i < 4; i++) chk($sformatf("t2 win[%0d]", i), w2[i], vals2[i]);
      chk("t2 out_last", ol2, 1);
      @(posedge clk); #1;

      // Backpressure on the first window for three cycles.
      do_reset();
      log_q.delete();
      fork
         send_frame(0);
         begin
            nwait = 0;
            seen  = 1'b0;
            while (!seen && nwait < 200) begin
               @(negedge clk);
               seen = in_valid && in_ready && (in_data == 5);
               nwait++;
            end
            chk("t3 saw pixel 5", seen, 1);
            or_val = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("t3 held out_valid", out_valid, 1);
               chk("t3 held in_ready", in_ready, 0);
               chk("t3 held w0", win_data[0], 0);
               chk("t3 held w1", win_data[1], 1);
               chk("t3 held w2", win_data[2], 4);
               chk("t3 held w3", win_data[3], 5);
               if (k == 2) or_val = 1'b1;
            end
         end
      join
      drain();
      chk("t3 windows", log_q.size(), 4);
      chk_frame0("t3", 0);

      // Reset in the middle of a frame.
      do_reset();
      for (int p = 0; p < 7; p++) send_pix(DW'(p));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4 out_valid after reset", out_valid, 0);
      log_q.delete();
      @(posedge clk); #1;
      send_frame(0);
      drain();
      chk("t4 windows", log_q.size(), 4);
      chk_frame0("t4", 0);

      // Two back-to-back frames with every third cycle idle.
      do_reset();
      log_q.delete();
      fd_pulses = 0;
      gap_mode  = 1;
      send_frame(0);
      send_frame(100);
      drain();
      gap_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("t5 windows", log_q.size(), 8);
      chk_frame0("t5", 0);
      chkw("t5 w4", 4, 100, 101, 104, 105, 0);
      chkw("t5 w7", 7, 110, 111, 114, 115, 1);
`ifdef POOL_WIN_STATUS_EN
      chk("t5 win_count", win_count, 8);
      chk("t5 frame_done pulses", fd_pulses, 2);
`endif

      // Random data, random gaps, random backpressure, one random mid-frame reset.
      do_reset();
      gap_mode = 2;
      or_rand  = 1'b1;
      for (int f = 0; f < 5; f++)
         for (int p = 0; p < W*H; p++) send_pix(DW'($urandom));
      for (int p = 0; p < int'($urandom_range(1, 20)); p++) send_pix(DW'($urandom));
      do_reset();
      for (int f = 0; f < 3; f++)
         for (int p = 0; p < W*H; p++) send_pix(DW'($urandom));
      drain();
      or_rand  = 1'b0;
      gap_mode = 0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Upstream feeder for the max-pooling stage.
- Accepts a raster-ordered feature-map pixel stream, one signed pixel per handshake, and buffers one even row in a line buffer.
- Emits each non-overlapping 2x2 window (stride 2) as four parallel signed words, which drive the pooling stage's 4-entry input array.
- Handshake is valid/ready on both sides, with full backpressure.

Parameters:
- DATA_WIDTH, 20, signed pixel width; matches the pooling stage INPUT_WIDTH.
- FMAP_WIDTH, 8, pixels per row; must be even and >= 2.
- FMAP_HEIGHT, 8, rows per frame; must be even and >= 2.
- POOL_SIZE, 4, words per window; fixed at 2*2, any other value is illegal.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_WIDTH  signed pixel, raster order: row 0 col 0 first.
- out_valid  out  1  win_data holds a complete window.
- out_ready  in  1  downstream accepts the window.
- win_data  out  POOL_SIZE x DATA_WIDTH  unpacked signed array. Index 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right.
- out_last  out  1  qualifies the final window of a frame; valid only while out_valid=1.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_last=0, win_data all 0.
  - col=0, row=0, state=FILL_TOP.
  - Line buffer is not cleared; its contents are don't-care.
  - in_ready=0 during the reset cycle.
- Accept rule: a pixel is accepted when in_valid && in_ready. in_ready = rst_n && !(out_valid && !out_ready), i.e. the block stalls only while a window is held unaccepted.
- Counters:
  - col increments on each accepted pixel and wraps at FMAP_WIDTH-1 -> 0.
  - row increments on col wrap and wraps at FMAP_HEIGHT-1 -> 0.
- FSM:
  - FILL_TOP (row even): accepted pixel is written to linebuf[col]. On col wrap -> FILL_BOT.
  - FILL_BOT (row odd):
    - Even col: pixel is stored in bl_reg.
    - Odd col: a window is formed as {linebuf[col-1], linebuf[col], bl_reg, in_data}.
    - On col wrap -> FILL_TOP.
- Output register:
  - The window is registered into win_data with out_valid=1 on the edge that accepts the bottom-right pixel; latency is 1 cycle.
  - out_last=1 when that pixel is at row FMAP_HEIGHT-1, col FMAP_WIDTH-1.
- Output hold: while out_valid && !out_ready, win_data and out_last hold stable and no pixel is accepted.
- Output clear: out_valid clears on out_ready unless a new window loads on the same edge.
- Simultaneous events: if out_ready=1 and a new bottom-right pixel is accepted on the same edge, the new window replaces the old one and out_valid stays 1. This gives full throughput: one window per 2 accepted bottom-row pixels, no bubbles.
- Frame wrap: after the last pixel of a frame the block returns to FILL_TOP with row=0 and col=0. The next frame streams back to back with no idle cycle.
- Arithmetic: none. Data passes unmodified and sign is preserved bit-exact.
- Reset mid-frame: a partially gathered window is discarded, and the first pixel after reset is treated as row 0 col 0.

Optional Feature:
- POOL_WIN_STATUS_EN defined:
  - Adds output win_count [15:0], which increments on each out_valid && out_ready and wraps at 0xFFFF -> 0. Resets to 0.
  - Adds output frame_done [0:0], a 1-cycle pulse on the edge after the out_last window is accepted. Resets to 0.
- Undefined: neither port nor its logic exists.

Test Plan:
- 4x4 frame, pixels 0..15, out_ready=1, in_valid continuous:
  - Windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15} appear one cycle after pixels 5, 7, 13, 15 are accepted.
  - out_last=1 only on the 4th window.
- Signed data: 2x2 frame {-1, -524288, 524287, 0} -> single window with exactly those four values, out_last=1.
- Backpressure, 4x4 frame: out_ready=0 for 3 cycles after the first window appears:
  - win_data stays {0,1,4,5} and out_valid=1.
  - in_ready=0 while the window is held.
  - No pixel is lost; the remaining windows match the first test.
- Reset mid-frame: assert rst_n=0 for 1 cycle after pixel 6 of a 4x4 frame, then send 0..15.
  - out_valid=0 immediately after reset.
  - The window sequence exactly matches the first test.
- Two back-to-back 4x4 frames (0..15, then 100..115), in_valid gapped every 3rd cycle:
  - 8 windows; the second frame's first window is {100,101,104,105}.
  - out_last is asserted on windows 4 and 8.
  - With POOL_WIN_STATUS_EN: win_count=8 and frame_done pulses twice.
